// File: rtl/sersub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM encoding, the default width and the counter-width helper.
package sersub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SERSUB_WIDTH_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: diff = a - b - bin, purely combinational.
// Ports: a, b, bin in; diff, bor out.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bor
);

  assign diff = a ^ b ^ bin;
  assign bor  = (~a & bin) | (b & bin) | (~a & b);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor a - b - bin, LSB first, one cell shared.
// Ports: clk, rst_n, start, a, b, bin in; busy, done, diff, bor out;
// ovf out only when SERSUB_OVF_EN is defined.
module bit_serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = SERSUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
`ifdef SERSUB_OVF_EN
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_ovf;
`endif

  logic             w_d;
  logic             w_bnext;
  logic [WIDTH-1:0] w_r_next;

  fs_bit_cell u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bor  (w_bnext)
  );

  // new bit enters at the MSB; after WIDTH shifts bit 0 is the first bit
  assign w_r_next = {w_d, r_r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bor    <= 1'b0;
`ifdef SERSUB_OVF_EN
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
`ifdef SERSUB_OVF_EN
            r_amsb   <= a[WIDTH-1];
            r_bmsb   <= b[WIDTH-1];
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_r_sr   <= w_r_next;
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff  <= w_r_next;
            r_bor   <= w_bnext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
`ifdef SERSUB_OVF_EN
            // w_d is the MSB of the new result
            r_ovf   <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bor  = r_bor;
`ifdef SERSUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Bit-serial WIDTH-bit subtract controller. It sequences one shared one-bit full-subtractor cell across the operand bits, LSB first, carrying the borrow in a flip-flop between cycles. It computes a − b − bin over WIDTH cycles with a start/busy/done handshake. The block sits beside the combinational subtractor cells and is used where area matters more than latency.

## Interface
- WIDTH, default 8: operand and result width; legal range 2 to 32.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured at the accepting edge.
- b  input  WIDTH  subtrahend; captured at the accepting edge.
- bin  input  1  borrow-in; captured at the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high while in DONE.
- diff  output  WIDTH  result register; holds the last completed result.
- bor  output  1  final borrow-out; holds the last completed value.
- ovf  output  1  signed overflow of the last result; present only with SERSUB_OVF_EN.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing bits; the count runs 0..WIDTH-1.
  - DONE: result valid, one cycle only.
- IDLE or DONE, start=1: load operand shift registers a_sr and b_sr, set borrow_q to bin, clear count, go to RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each edge:
  - Cell inputs are a_sr[0], b_sr[0] and borrow_q.
  - d = a^b^borrow_q.
  - borrow_next = (~a&borrow_q) | (b&borrow_q) | (~a&b).
  - Shift d into result shift register r_sr at the MSB end, and shift a_sr and b_sr right.
  - borrow_q takes borrow_next; count increments.
- RUN, edge with count = WIDTH-1:
  - diff takes the final r_sr contents, including this edge's bit.
  - bor takes borrow_next.
  - Go to DONE.
- start during RUN is ignored. There is no queueing and no error flag.
- a, b and bin are don't-care except at the accepting edge.
- Result is modulo 2^WIDTH. bor=1 exactly when a < b + bin as unsigned values.
- diff and bor change only on the completion edge. They are stable at all other times, including throughout the next operation.

## Timing
- Reset values: state IDLE, busy 0, done 0, diff 0, bor 0, ovf 0, all internal registers 0.
- Accepting edge = edge E0. busy is high after E0 through edge E_WIDTH.
- done is high for exactly the cycle after E_WIDTH. Latency from acceptance to done is WIDTH cycles.
- Back-to-back: start=1 while done=1 is accepted. The next operation's busy rises in the following cycle, so throughput is one result per WIDTH+1 cycles.
- Reset asserted at any time, including mid-RUN: all registers clear immediately and the operation is abandoned with no done.
- After reset deassertion, the first start is accepted on the first rising edge that samples start=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SERSUB_OVF_EN defined:
  - Port ovf exists.
  - The MSBs of a and b are captured at acceptance.
  - On the completion edge, ovf = (a_msb ^ b_msb) & (diff_msb_new ^ a_msb), i.e. signed two's-complement overflow of a − b − bin.
  - ovf holds its value until the next completion or reset.
- SERSUB_OVF_EN undefined:
  - No ovf port and no MSB capture registers.
  - All other behaviour is identical.

## Structure
- Shared package sersub_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; the value 2'd3 recovers to IDLE.
  - Default WIDTH.
  - Count width function clog2(WIDTH).
- One sub-module, fs_bit_cell: purely combinational one-bit full subtractor with inputs a, b, bin and outputs diff, bor. It is instantiated once and carries no state.
- The top level holds:
  - the FSM;
  - the counter;
  - shift registers a_sr, b_sr and r_sr;
  - borrow_q and the output registers.

## Test plan
All scenarios use WIDTH=8.
- Basic subtract: a=0x05, b=0x03, bin=0, start pulse. Required: busy high for 8 cycles, done pulse in the 9th cycle, diff=0x02, bor=0.
- Underflow: a=0x03, b=0x05, bin=0. Required: diff=0xFE, bor=1. Then a=0x00, b=0x00, bin=1. Required: diff=0xFF, bor=1.
- start held high during RUN: a second operand set applied mid-run is ignored. Required: first result correct and exactly one done.
- Back-to-back:
  - 0x10 − 0x01 with start held high through done.
  - Then 0x20 − 0x20.
  - Required: diff=0x0F then 0x00, consecutive done pulses 9 cycles apart.
- Reset mid-op: rst_n pulsed low at the 4th RUN cycle. Required: all outputs 0 immediately, no done, and the next start completes correctly.
- With SERSUB_OVF_EN defined:
  - a=0x80, b=0x01. Required: diff=0x7F, ovf=1.
  - a=0x7F, b=0x01. Required: diff=0x7E, ovf=0.
